// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, read-enable
// pattern and default geometry of the 32-word data memory.
package dm_arbiter_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [3:0] WEN_READ = 4'b0000;

endpackage

// File: rtl/dm_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: a lone request wins outright, a tie
// goes to whichever requester was not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       sel
);

  always_comb begin
    gnt_valid = |req;
    sel       = 1'b0;
    case (req)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~last_grant;
      default: sel = 1'b0;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester arbiter and access sequencer for the synchronous-write,
// asynchronous-read data memory; one access per grant, acknowledged two cycles later.
//
// state  | meaning
// IDLE   | waiting for a request; grants and latches the winner's fields
// ACCESS | memory port driven for one cycle; read data captured at its end
// DONE   | winner's ack pulses with the captured read data
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  m0_req,
  input  logic [DATA_W/8-1:0]   m0_wen,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic                  m1_req,
  input  logic [DATA_W/8-1:0]   m1_wen,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic [DATA_W/8-1:0]   ram_wen,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic                  busy
);

  localparam int WEN_W = DATA_W / 8;
  localparam logic [WEN_W-1:0] WEN_IDLE = WEN_W'(WEN_READ);

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              sel_q, sel_d;
  logic [WEN_W-1:0]  wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  logic gnt_valid;
  logic arb_sel;

  rr_arb2 u_rr_arb2 (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .sel        (arb_sel)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          sel_d        = arb_sel;
          last_grant_d = arb_sel;
          wen_d        = arb_sel ? m1_wen   : m0_wen;
          addr_d       = arb_sel ? m1_addr  : m0_addr;
          wdata_d      = arb_sel ? m1_wdata : m0_wdata;
          state_d      = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Sampled at the same edge the memory commits, so a write returns the old word.
        if (sel_q) m1_rdata_d = ram_rdata;
        else       m0_rdata_d = ram_rdata;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      sel_q        <= 1'b0;
      wen_q        <= WEN_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  // Gating with resetn keeps a write from committing on a reset edge.
  assign ram_wen   = (state_q == ST_ACCESS && resetn) ? wen_q : WEN_IDLE;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign m0_ack    = (state_q == ST_DONE) && !sel_q;
  assign m1_ack    = (state_q == ST_DONE) &&  sel_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: a behavioural data memory, directed
// transactions with expected acks queued in grant order, and a negedge monitor.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [3:0]  m0_wen = '0, m1_wen = '0;
  logic [4:0]  m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [3:0]  ram_wen;
  logic [4:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        busy;

  dm_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [32];
  initial for (int i = 0; i < 32; i++) mem[i] = '0;
  always @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (ram_wen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
  assign ram_rdata = mem[ram_addr];

  typedef struct {
    int          id;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wen_cycles = 0;
  logic [3:0] last_wen = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic void push(int id, logic [31:0] rdata);
    exp_t e;
    e.id = id;
    e.rdata = rdata;
    exp_q.push_back(e);
  endfunction

  function automatic void score(int id, logic [31:0] rdata);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ack: got ack from m%0d expected none", id);
    end else begin
      e = exp_q.pop_front();
      check("grant_order", 32'(id), 32'(e.id));
      check("ack_rdata", rdata, e.rdata);
    end
  endfunction

  always @(negedge clk) begin
    if (ram_wen != 4'b0000) begin
      wen_cycles++;
      last_wen = ram_wen;
      check("wen_only_in_access", 32'(busy && !m0_ack && !m1_ack), 32'd1);
    end
    if (m0_ack || m1_ack) check("ack_exclusive", 32'(m0_ack && m1_ack), 32'd0);
    if (m0_ack) score(0, m0_rdata);
    if (m1_ack) score(1, m1_rdata);
  end

  task automatic set_req(input int id, input logic req, input logic [3:0] wen,
                         input logic [4:0] addr, input logic [31:0] wdata);
    if (id == 0) begin
      m0_req = req; m0_wen = wen; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_wen = wen; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  // Presents one request, waits (bounded) for its ack; returns latency and ack cycle.
  task automatic drive(input int id, input logic [3:0] wen, input logic [4:0] addr,
                       input logic [31:0] wdata, input bit hold,
                       output int lat, output int ack_c);
    int start;
    bit got;
    start = cyc;
    got = 1'b0;
    set_req(id, 1'b1, wen, addr, wdata);
    for (int i = 0; i < 30 && !got; i++) begin
      @(posedge clk); #1;
      got = (id == 0) ? m0_ack : m1_ack;
    end
    lat = cyc - start;
    ack_c = cyc;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: m%0d no ack after 30 cycles expected ack", id);
    end
    if (!hold) set_req(id, 1'b0, wen, addr, wdata);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_m0_ack"},   32'(m0_ack), 32'd0);
    check({tag, "_m1_ack"},   32'(m1_ack), 32'd0);
    check({tag, "_m0_rdata"}, m0_rdata, 32'd0);
    check({tag, "_m1_rdata"}, m1_rdata, 32'd0);
    check({tag, "_ram_wen"},  32'(ram_wen), 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_wdata"}, ram_wdata, 32'd0);
    check({tag, "_busy"},     32'(busy), 32'd0);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check_zero("reset");
    resetn = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat0, lat1, ac0, ac1, w0, n;

    @(posedge clk); #1;
    apply_reset();

    // full-word write then read-back
    w0 = wen_cycles;
    push(0, 32'h0000_0000);
    drive(0, 4'b1111, 5'd3, 32'h1234_5678, 1'b0, lat0, ac0);
    check("t1_ack_latency", 32'(lat0), 32'd2);
    check("t1_wen_cycles", 32'(wen_cycles - w0), 32'd1);
    check("t1_wen_value", 32'(last_wen), 32'h0000_000F);
    next_cycle();
    check("t1_ack_single", 32'(m0_ack), 32'd0);
    push(0, 32'h1234_5678);
    drive(0, 4'b0000, 5'd3, 32'h0, 1'b0, lat0, ac0);
    next_cycle();

    // simultaneous reads after reset: m0 first, acks 3 cycles apart
    apply_reset();
    push(0, 32'h1234_5678);
    push(1, 32'h0000_0000);
    fork
      drive(0, 4'b0000, 5'd3, 32'h0, 1'b0, lat0, ac0);
      drive(1, 4'b0000, 5'd5, 32'h0, 1'b0, lat1, ac1);
    join
    check("t2_m0_latency", 32'(lat0), 32'd2);
    check("t2_ack_spacing", 32'(ac1 - ac0), 32'd3);
    next_cycle();

    // both hold req for six accesses: strict alternation 0,1,0,1,0,1
    push(0, 32'h0000_0000);
    push(1, 32'h0000_0000);
    push(0, 32'hA0A0_0001);
    push(1, 32'hA0A0_0001);
    push(0, 32'hA0A0_0002);
    push(1, 32'hA0A0_0002);
    fork
      begin
        drive(0, 4'b0000, 5'd10, 32'h0, 1'b1, lat0, ac0);
        drive(0, 4'b0000, 5'd10, 32'h0, 1'b1, lat0, ac0);
        drive(0, 4'b0000, 5'd10, 32'h0, 1'b0, lat0, ac0);
      end
      begin
        drive(1, 4'b1111, 5'd10, 32'hA0A0_0001, 1'b1, lat1, ac1);
        drive(1, 4'b1111, 5'd10, 32'hA0A0_0002, 1'b1, lat1, ac1);
        drive(1, 4'b1111, 5'd10, 32'hA0A0_0003, 1'b0, lat1, ac1);
      end
    join
    check("t3_last_ack_gap", 32'(ac1 - ac0), 32'd3);
    next_cycle();

    // byte-lane write into a prefilled word
    push(1, 32'h0000_0000);
    drive(1, 4'b1111, 5'd7, 32'h1122_3344, 1'b0, lat1, ac1);
    next_cycle();
    push(0, 32'h1122_3344);
    drive(0, 4'b0100, 5'd7, 32'hAABB_CCDD, 1'b0, lat0, ac0);
    next_cycle();
    push(0, 32'h11BB_3344);
    drive(0, 4'b0000, 5'd7, 32'h0, 1'b0, lat0, ac0);
    next_cycle();

    // reset during ACCESS aborts the write and the ack
    set_req(0, 1'b1, 4'b1111, 5'd9, 32'hDEAD_BEEF);
    next_cycle();
    check("t5_access_wen", 32'(ram_wen), 32'h0000_000F);
    check("t5_access_busy", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    check("t5_wen_gated", 32'(ram_wen), 32'd0);
    next_cycle();
    check_zero("abort");
    set_req(0, 1'b0, 4'b0000, 5'd0, 32'h0);
    next_cycle();
    resetn = 1'b1;
    next_cycle();
    push(0, 32'h0000_0000);
    push(1, 32'h1234_5678);
    fork
      drive(0, 4'b0000, 5'd9, 32'h0, 1'b0, lat0, ac0);
      drive(1, 4'b0000, 5'd3, 32'h0, 1'b0, lat1, ac1);
    join
    check("t5_post_reset_order", 32'(ac0 < ac1), 32'd1);
    next_cycle();

    // m1 drops req right after its grant edge
    push(1, 32'h11BB_3344);
    set_req(1, 1'b1, 4'b0000, 5'd7, 32'h0);
    next_cycle();
    set_req(1, 1'b0, 4'b0000, 5'd7, 32'h0);
    n = 0;
    repeat (8) begin
      next_cycle();
      if (m1_ack) n++;
    end
    check("t6_single_ack", 32'(n), 32'd1);

    repeat (3) next_cycle();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Two-requester arbiter and access sequencer for the 32-word synchronous-write, asynchronous-read data memory.
- Requester 0 is the CPU load/store port; requester 1 is the debug/DMA port.
- The block grants one requester at a time under round-robin, drives the memory port for exactly one access cycle, then returns registered read data with a one-cycle acknowledge.
- It sits between the requesters and the data memory's (wen, addr, wdata, rdata) port.

Parameters:
ADDR_W, 5, word address width (32 words)
DATA_W, 32, data width; byte-enable width is DATA_W/8 = 4

Ports:
clk  input  1  clock, all state on rising edge
resetn  input  1  synchronous reset, active low
m0_req  input  1  requester 0 access request, held until m0_ack
m0_wen  input  4  requester 0 byte write enables; 0000 = read
m0_addr  input  ADDR_W  requester 0 word address
m0_wdata  input  DATA_W  requester 0 write data
m0_ack  output  1  one-cycle completion pulse to requester 0
m0_rdata  output  DATA_W  requester 0 read data, valid while m0_ack=1
m1_req, m1_wen, m1_addr, m1_wdata, m1_ack, m1_rdata  same as m0_* for requester 1
ram_wen  output  4  byte write enables to memory
ram_addr  output  ADDR_W  address to memory
ram_wdata  output  DATA_W  write data to memory
ram_rdata  input  DATA_W  asynchronous read data from memory
busy  output  1  high in ACCESS and DONE

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, named resetn.
- Reset (resetn=0 at a clk edge):
  - state=IDLE, last_grant=1, so requester 0 wins the first tie.
  - All outputs are 0: m*_ack, m*_rdata, ram_wen, ram_addr, ram_wdata, busy.
  - Reset in any state aborts the access. If reset lands in ACCESS, ram_wen is forced to 0 in that same edge's next cycle; a write already presented in that cycle commits only if the edge is not a reset edge.
- FSM states:
  - IDLE: if no req, stay. If exactly one req, grant it. If both, grant the requester that is not last_grant.
    - On grant: latch sel, wen, addr, wdata into the ram_* registers; last_grant<=sel; go to ACCESS.
  - ACCESS (1 cycle): ram_wen = latched wen. The memory writes the enabled bytes at the end of this cycle. ram_rdata is captured into rdata_q at the end of this cycle (pre-write value for a write). Go to DONE.
  - DONE (1 cycle): ram_wen=0. m{sel}_ack=1 and m{sel}_rdata=rdata_q; the other requester's ack=0. Go to IDLE.
- Latency: request seen in IDLE at edge N, ACCESS in cycle N+1, ack in cycle N+2. Sustained throughput is one access per 3 cycles.
- ram_wen is nonzero only in ACCESS. ram_addr and ram_wdata hold their latched values outside ACCESS; they only change on a grant.
- m*_rdata holds its last value after ack; it is only meaningful while ack=1.
- Handshake:
  - A requester keeps req and its fields stable until ack.
  - After ack it must deassert req, or present a new request, in the cycle after ack. A req still high in IDLE is treated as a new request.
  - A req dropped after the grant edge does not cancel the access: it completes and ack still pulses.
- A requester arriving while the arbiter is busy waits. In the following IDLE the round-robin guarantees alternation, so neither requester waits more than one other access.
- Mixed byte enables (e.g. 0110) pass through unchanged. There is no address range check: ADDR_W bits cover the whole memory.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), WEN_READ=4'b0000, and the ADDR_W/DATA_W defaults.
- One natural sub-module: rr_arb2, the combinational 2-way round-robin picker (inputs req[1:0] and last_grant; outputs gnt_valid and sel).
- The FSM and datapath latch remain in dm_arbiter.

Test Plan:
- Reset, then m0 writes wen=1111 addr=3 wdata=0x12345678 -> ram_wen=1111 in exactly one cycle. m0_ack pulses 2 cycles after the grant edge. A following m0 read of addr=3 returns m0_rdata=0x12345678.
- Simultaneous m0 and m1 reads after reset -> m0 is served first and m1 second. Each ack is a single-cycle pulse, ack edges are 3 cycles apart, and m1_ack=0 during m0_ack.
- Both requesters hold req continuously for 6 accesses -> grants alternate 0,1,0,1,0,1 and ram_wen never asserts outside ACCESS.
- Byte write wen=0100 wdata=0xAABBCCDD to addr=7 previously holding 0x11223344 -> a later read returns 0x11BB3344. The rdata returned with the write ack is 0x11223344.
- resetn=0 asserted during ACCESS of a pending write -> all outputs are 0 the next cycle and no ack is issued. After release, IDLE with last_grant=1, so simultaneous requests grant m0.
- m1 drops req the cycle after its grant edge -> the access still completes and m1_ack pulses once. No second access occurs for m1.
